// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the EX-stage divide sequencer.
// Op decode helpers keep signedness/remainder selection consistent across files.
package div_seq_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Selects one of two values and conditionally two's-complements it.
// Used for operand magnitudes on the way in and quotient/remainder sign on the way out.
module div_sign_fixup #(
  parameter int unsigned XLEN = 32
) (
  input  logic            sel,
  input  logic            neg,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [XLEN-1:0] pick;

  always_comb begin
    pick = sel ? b : a;
    y    = neg ? -pick : pick;
  end

endmodule

// File: rtl/div_sequencer.sv
// Controller around the multi-cycle unsigned divider core: resets and issues the core,
// resolves divide-by-zero/overflow locally, applies sign fix-up and stalls the pipeline.
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            div_req,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            core_aresetn,
  output logic            core_in_valid,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  input  logic            core_out_valid,
  input  logic [XLEN-1:0] core_quotient,
  input  logic [XLEN-1:0] core_remainder,
  output logic            div_stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_timeout
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Special-result constants are defined for the CPU's 32-bit datapath.
  localparam logic [XLEN-1:0] MIN_VAL = XLEN'(INT_MIN);
  localparam logic [XLEN-1:0] ONES    = XLEN'(ALL_ONES);

  state_e          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  div_op_e         op_q, op_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [XLEN-1:0] dd_q, dd_d, dv_q, dv_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            timeout_q, timeout_d;
  logic            core_rstn_q, core_rstn_d;

  div_op_e         op_in;
  logic            in_signed, in_rem, rs1_neg, rs2_neg;
  logic            div_zero, ovf, req_ok, fix_neg, fix_rem;
  logic [XLEN-1:0] mag1, mag2, fixed, special_res;

  assign op_in     = div_op_e'(div_op);
  assign in_signed = op_is_signed(op_in);
  assign in_rem    = op_is_rem(op_in);
  assign rs1_neg   = in_signed & rs1_val[XLEN-1];
  assign rs2_neg   = in_signed & rs2_val[XLEN-1];
  assign req_ok    = div_req & ~flush;
  assign div_zero  = (rs2_val == '0);
  assign ovf       = in_signed & (rs1_val == MIN_VAL) & (rs2_val == ONES);
  assign special_res = div_zero ? (in_rem ? rs1_val : ONES)
                                : (in_rem ? '0 : MIN_VAL);

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign fix_rem = op_is_rem(op_q);
  assign fix_neg = fix_rem ? a_neg_q : (a_neg_q ^ b_neg_q);

  div_sign_fixup #(.XLEN(XLEN)) u_mag_a (
    .sel(1'b0), .neg(rs1_neg), .a(rs1_val), .b(rs2_val), .y(mag1)
  );

  div_sign_fixup #(.XLEN(XLEN)) u_mag_b (
    .sel(1'b0), .neg(rs2_neg), .a(rs2_val), .b(rs1_val), .y(mag2)
  );

  div_sign_fixup #(.XLEN(XLEN)) u_fix (
    .sel(fix_rem), .neg(fix_neg), .a(core_quotient), .b(core_remainder), .y(fixed)
  );

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    op_d       = op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    dd_d       = dd_q;
    dv_d       = dv_q;
    result_d   = result_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        if (req_ok) begin
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            op_d      = op_in;
            a_neg_d   = rs1_neg;
            b_neg_d   = rs2_neg;
            dd_d      = mag1;
            dv_d      = mag2;
            rst_cnt_d = RCW'(RST_CYCLES - 1);
            state_d   = RST;
          end
        end
      end
      RST: begin
        if (rst_cnt_q == '0) state_d = ISSUE;
        else rst_cnt_d = rst_cnt_q - RCW'(1);
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_out_valid) begin
          result_d = fixed;
          state_d  = DONE;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A squash discards anything this cycle would have captured.
    if (flush) begin
      state_d   = IDLE;
      result_d  = result_q;
      timeout_d = timeout_q;
    end

    core_rstn_d = (state_d != RST) &&
                  !(flush && (state_q inside {RST, ISSUE, WAIT}));
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      op_q        <= OP_DIV;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      dd_q        <= '0;
      dv_q        <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      op_q        <= op_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      dd_q        <= dd_d;
      dv_q        <= dv_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  assign core_aresetn  = core_rstn_q;
  assign core_in_valid = (state_q == ISSUE) & ~flush;
  assign core_dividend = dd_q;
  assign core_divisor  = dv_q;
  assign div_stall     = aresetn & req_ok & (state_q != DONE);
  assign result_valid  = (state_q == DONE);
  assign result        = result_q;
  assign div_timeout   = timeout_q;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Controls the multi-cycle unsigned divider core used by the EX stage of the pipelined CPU for DIV/DIVU/REM/REMU.
- On each divide it resets the core, converts signed operands to magnitudes, issues the operands and waits for the core's result handshake.
- It then applies the sign fix-up and drives the pipeline stall until the result is ready.
- Divide-by-zero and signed overflow are resolved in the controller and never reach the core.

Parameters:
- RST_CYCLES, 2, cycles core_aresetn is held low before each issue (must be ≥1).
- TIMEOUT, 64, maximum cycles spent in WAIT before a forced abort.
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- div_req  in  1  EX holds a valid divide op (level, held while stalled)
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_val  in  XLEN  dividend
- rs2_val  in  XLEN  divisor
- flush  in  1  EX squashed; abort any divide
- core_aresetn  out  1  divider core reset, active low
- core_in_valid  out  1  one-cycle operand strobe to core
- core_dividend  out  XLEN  unsigned magnitude
- core_divisor  out  XLEN  unsigned magnitude
- core_out_valid  in  1  core result strobe
- core_quotient  in  XLEN  unsigned quotient
- core_remainder  in  XLEN  unsigned remainder
- div_stall  out  1  freeze IF/ID/EX
- result_valid  out  1  one-cycle result strobe to EX/MEM
- result  out  XLEN  final rd value
- div_timeout  out  1  sticky error flag

Behaviour:
- Clock/reset: single clock clk; aresetn is asynchronous, active-low.
- Reset values: state=IDLE, core_aresetn=0, core_in_valid=0, result_valid=0, result=0, div_timeout=0, counters=0. div_stall=0 while aresetn is low.
- States:
  - IDLE: core_aresetn=1. If div_req & !flush:
    - divisor==0 or (op==DIV/REM & rs1==0x80000000 & rs2==0xFFFFFFFF) → latch special result, go DONE.
    - otherwise latch op, operand signs and magnitudes, go RST.
  - RST: core_aresetn=0 for RST_CYCLES cycles (down-counter), then go ISSUE.
  - ISSUE: core_aresetn=1, core_in_valid=1 for exactly one cycle, clear the wait counter, go WAIT.
  - WAIT: increment the wait counter each cycle.
    - core_out_valid=1 → capture the fixed-up result, go DONE.
    - counter reaches TIMEOUT → result=0, set div_timeout, go DONE.
  - DONE: result_valid=1 for one cycle, go IDLE.
- Stall: div_stall = div_req & !flush & (state != DONE). It is combinational, so it rises in the same cycle div_req first appears and falls in the DONE cycle, letting the pipeline advance with the result.
- Signed ops: magnitude = two's complement of the operand if its MSB is set.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops pass operands and results through unchanged.
- Special results:
  - Divide by zero: DIV/DIVU=0xFFFFFFFF; REM/REMU=rs1.
  - Overflow: DIV=0x80000000; REM=0.
- Latency: normal op total stall cycles = 1 (IDLE) + RST_CYCLES + 1 (ISSUE) + L, where L = core latency from core_in_valid to core_out_valid. result_valid follows in the next cycle. Special op: stall 1 cycle, result_valid in cycle 1.
- flush in any state: next state IDLE, no result_valid. If the state was RST/ISSUE/WAIT, core_aresetn=0 next cycle; a late core_out_valid is ignored.
- core_out_valid outside WAIT is ignored.
- A new div_req in DONE is not accepted until IDLE.
- div_timeout clears only on reset.
- Operands are latched at acceptance; later changes on rs1/rs2 are ignored.

Decomposition:
- Package div_seq_pkg holds:
  - div_op encodings: OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - State encoding: IDLE, RST, ISSUE, WAIT, DONE.
  - Constants: INT_MIN=0x80000000, ALL_ONES.
- Sub-module div_sign_fixup (combinational): operand magnitudes plus result negation/selection. Reused for both pre- and post-processing.

Test Plan:
- DIV rs1=-20 (0xFFFFFFEC), rs2=3, core L=8, RST_CYCLES=2 → div_stall high for 12 cycles; core_dividend=20, core_divisor=3; result_valid in cycle 12 with result=0xFFFFFFFA (-6).
- REM rs1=-20, rs2=3 → result=0xFFFFFFFE (-2).
- REMU rs1=20, rs2=3 → result=2; core_aresetn low exactly 2 cycles before core_in_valid.
- DIVU rs2=0 → core_in_valid never asserts; stall 1 cycle; result=0xFFFFFFFF. REM rs2=0, rs1=7 → result=7.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → result=0x80000000 after 1 stall cycle; REM of the same → 0.
- flush in WAIT cycle 3 → state IDLE; no result_valid; core_out_valid 5 cycles later ignored; the next DIV 9/2 returns 4.
- Core never responds, TIMEOUT=64 → result_valid with result=0 and div_timeout=1; aresetn low clears div_timeout.
